lcd_pixel_prefetch: RTL and testbench
=====================================

LCD_PIXEL_PREFETCH -- requirements
Module: lcd_pixel_prefetch

Interface
REQ-001 The block SHALL have parameter H_RES, default 160, meaning pixels per line.
REQ-002 The block SHALL have parameter V_RES, default 80, meaning lines per frame.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the pixel FIFO depth (power of two, 2..16).
REQ-004 Port clk  input  1  the single system clock (10 MHz); all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port frame_start  input  1  one-cycle pulse from the LCD controller at the start of each pixel-data phase.
REQ-007 Port fb_rd_en  output  1  framebuffer read strobe.
REQ-008 Port fb_rd_addr  output  14  framebuffer word address, valid when fb_rd_en=1.
REQ-009 Port fb_rd_data  input  16  RGB565 read data, valid exactly 1 cycle after fb_rd_en.
REQ-010 Port pix_pop  input  1  LCD-side request to consume the head pixel.
REQ-011 Port pix_data  output  16  head-of-FIFO RGB565 pixel (show-ahead).
REQ-012 Port pix_valid  output  1  FIFO non-empty.
REQ-013 Port fifo_level  output  5  number of pixels stored (0..DEPTH).
REQ-014 Port underflow  output  1  sticky flag: a pop was attempted while empty.
REQ-015 Port frame_done  output  1  high once all H_RES*V_RES addresses of the frame are issued.

Function
REQ-016 Addresses SHALL be issued in raster order, addr = V*H_RES + H, via incrementing H (0..H_RES-1) and V (0..V_RES-1) counters; no multiplier.
REQ-017 fb_rd_en SHALL assert in a cycle iff frame_done=0, frame_start=0, and fifo_level + inflight + (read issued in the previous cycle not yet written) < DEPTH, so the FIFO never overflows.
REQ-018 Each fb_rd_data word SHALL be written into the FIFO in the cycle it is valid; read latency from fb_rd_en to pix_valid SHALL be 2 cycles when the FIFO is empty.
REQ-019 A pop SHALL occur iff pix_pop=1 and pix_valid=1; pix_data SHALL then advance to the next entry, or pix_valid drops if none remain.
REQ-020 A simultaneous write and pop SHALL leave fifo_level unchanged and preserve order.
REQ-021 pix_pop=1 with pix_valid=0 SHALL set underflow, leave the FIFO unchanged, and output no data.
REQ-022 After address H_RES*V_RES-1 is issued, frame_done SHALL go high the next cycle and no further reads are issued until frame_start.
REQ-023 frame_start SHALL have priority over all other events in that cycle: flush the FIFO (level 0), clear H/V to 0, clear frame_done and underflow, and suppress fb_rd_en that cycle.
REQ-024 A read issued in the cycle before frame_start SHALL have its returning data discarded (not written).
REQ-025 The first read of a new frame (address 0) SHALL issue the cycle after frame_start.
REQ-026 fifo_level SHALL be a registered count, never exceeding DEPTH and never wrapping below 0.

Reset
REQ-027 While rst_n=0, asynchronously: fb_rd_en=0, fb_rd_addr=0, pix_valid=0, pix_data=0, fifo_level=0, underflow=0, H=V=0, in-flight flag=0.
REQ-028 While rst_n=0, frame_done SHALL be 1, so that no reads are issued after reset until the first frame_start.
REQ-029 Deassertion of rst_n mid-frame SHALL NOT resume the previous frame; operation restarts only on frame_start.

Verification
REQ-030 Reset, then frame_start, with fb_rd_data=addr and no pops -> reads at addresses 0,1,2,3; fb_rd_en then held low; fifo_level=4; pix_data=0x0000.
REQ-031 Continuous pix_pop=1 across a full frame -> 12800 pixels popped with values 0..12799 in order; frame_done rises after address 12799; underflow=0 at the end of the frame.
REQ-032 Address sequence spot-check -> address after 159 is 160 (H wraps to 0, V to 1); last address 12799 = V 79, H 159.
REQ-033 pix_pop pulsed with the FIFO empty right after frame_start -> underflow=1, fifo_level stays 0; next frame_start clears it.
REQ-034 frame_start asserted while fifo_level=3 and a read is in flight -> next cycle fifo_level=0, stale data discarded, next issued address=0.
REQ-035 rst_n pulsed low mid-frame with the FIFO holding 2 pixels -> all outputs at reset values immediately; no fb_rd_en until frame_start.

Source files
------------

// File: rtl/lcd_pixel_prefetch.sv
// Purpose: prefetches framebuffer pixels in raster order into a small show-ahead FIFO for the LCD.
// Latency: 2 cycles from fb_rd_en to pix_valid when the FIFO is empty.
// Backpressure: reads are throttled so stored plus in-flight pixels never exceed DEPTH.
//
// Ports: clk/rst_n (async active-low), frame_start (restart pulse),
//        fb_rd_en/fb_rd_addr/fb_rd_data (framebuffer read, 1-cycle data latency),
//        pix_pop/pix_data/pix_valid/fifo_level (LCD-side FIFO), underflow, frame_done.
module lcd_pixel_prefetch #(
    parameter int H_RES = 160,
    parameter int V_RES = 80,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        fb_rd_en,
    output logic [13:0] fb_rd_addr,
    input  logic [15:0] fb_rd_data,
    input  logic        pix_pop,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [4:0]  fifo_level,
    output logic        underflow,
    output logic        frame_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int VW = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic [HW-1:0]  h_q;
    logic [VW-1:0]  v_q;
    logic [13:0]    addr_q;
    logic           done_q;
    logic           pend_q;     // read issued last cycle, data arriving this cycle
    logic           under_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [4:0]     level_q;
    logic [15:0]    mem [DEPTH];

    logic h_last;
    logic last_pix;
    logic do_wr;
    logic do_pop;
    logic [5:0] committed;

    assign h_last    = (h_q == HW'(H_RES - 1));
    assign last_pix  = h_last && (v_q == VW'(V_RES - 1));

    // Count the pending return as occupied so the write slot is guaranteed.
    assign committed = {1'b0, level_q} + {5'b0, pend_q};

    assign fb_rd_en   = !done_q && !frame_start && (committed < 6'(DEPTH));
    assign fb_rd_addr = addr_q;

    assign pix_valid  = (level_q != 5'd0);
    assign pix_data   = pix_valid ? mem[rd_ptr_q] : 16'h0000;
    assign fifo_level = level_q;
    assign underflow  = under_q;
    assign frame_done = done_q;

    // frame_start flushes, so neither the returning stale word nor a pop takes effect.
    assign do_wr  = pend_q && !frame_start;
    assign do_pop = pix_pop && pix_valid && !frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '0;
            v_q      <= '0;
            addr_q   <= '0;
            done_q   <= 1'b1;
            pend_q   <= 1'b0;
            under_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (frame_start) begin
            h_q      <= '0;
            v_q      <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            under_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            pend_q <= fb_rd_en;
            if (fb_rd_en) begin
                if (last_pix) begin
                    done_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + 14'd1;
                    if (h_last) begin
                        h_q <= '0;
                        v_q <= v_q + VW'(1);
                    end else begin
                        h_q <= h_q + HW'(1);
                    end
                end
            end
            if (pix_pop && !pix_valid) begin
                under_q <= 1'b1;
            end
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_q + 5'(do_wr) - 5'(do_pop);
        end
    end

    // Storage needs no reset: pix_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= fb_rd_data;
        end
    end

endmodule

// File: tb/tb_lcd_pixel_prefetch.sv
// Purpose: directed self-checking bench for lcd_pixel_prefetch.
// Latency: framebuffer model returns data one cycle after each read strobe.
// Backpressure: LCD side pops whenever a pixel is shown as valid.
module tb_lcd_pixel_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        fb_rd_en;
    logic [13:0] fb_rd_addr;
    logic [15:0] fb_rd_data = 16'h0;
    logic        pix_pop;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic [4:0]  fifo_level;
    logic        underflow;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    lcd_pixel_prefetch #(.H_RES(160), .V_RES(80), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .fb_rd_en   (fb_rd_en),
        .fb_rd_addr (fb_rd_addr),
        .fb_rd_data (fb_rd_data),
        .pix_pop    (pix_pop),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .fifo_level (fifo_level),
        .underflow  (underflow),
        .frame_done (frame_done)
    );

    always #50 clk = ~clk;

    // Framebuffer model: word content equals its address, one-cycle latency.
    always @(posedge clk) fb_rd_data <= {2'b00, fb_rd_addr};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int nrd;
        int npop;
        int errs_a;
        int errs_p;
        int seen;
        bit lvl_chk;
        bit last_seen;
        bit done_chk;
        logic [13:0] addrs [4];
        logic vhist [10];

        rst_n = 1'b0;
        frame_start = 1'b0;
        pix_pop = 1'b0;
        step();
        step();
        chk("rst_rd_en",   fb_rd_en,   0);
        chk("rst_addr",    fb_rd_addr, 0);
        chk("rst_valid",   pix_valid,  0);
        chk("rst_data",    pix_data,   0);
        chk("rst_level",   fifo_level, 0);
        chk("rst_under",   underflow,  0);
        chk("rst_done",    frame_done, 1);

        rst_n = 1'b1;
        step(); step(); step();
        chk("idle_no_rd",  fb_rd_en,   0);

        // Fill with no pops: exactly four reads at 0..3.
        frame_start = 1'b1;
        #1;
        chk("fs_suppress", fb_rd_en, 0);
        step();
        frame_start = 1'b0;
        #1;
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            if (fb_rd_en) begin
                if (nrd < 4) addrs[nrd] = fb_rd_addr;
                nrd++;
            end
            vhist[i] = pix_valid;
            step();
        end
        chk("fill_rd_cnt", nrd, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("fill_addr%0d", i), addrs[i], i);
        chk("lat_valid_c1", vhist[1], 0);
        chk("lat_valid_c2", vhist[2], 1);
        chk("fill_level",   fifo_level, 4);
        chk("fill_head",    pix_data,   0);

        // Two pops, then frame_start with level 3 and a read in flight.
        pix_pop = 1'b1;
        chk("pop0_data", pix_data, 0);
        step();
        chk("pop1_level", fifo_level, 3);
        chk("pop1_rd_en", fb_rd_en, 1);
        chk("pop1_addr",  fb_rd_addr, 4);
        chk("pop1_data",  pix_data, 1);
        step();
        pix_pop = 1'b0;
        chk("n2_level", fifo_level, 2);
        chk("n2_addr",  fb_rd_addr, 5);
        chk("n2_data",  pix_data, 2);
        step();
        chk("n3_level", fifo_level, 3);
        chk("n3_rd_en", fb_rd_en, 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        #1;
        chk("flush_level", fifo_level, 0);
        chk("flush_valid", pix_valid, 0);
        chk("flush_rd_en", fb_rd_en, 1);
        chk("flush_addr",  fb_rd_addr, 0);
        step();
        chk("stale_dropped", fifo_level, 0);
        step();
        chk("new_valid", pix_valid, 1);
        chk("new_head",  pix_data, 0);

        // Pop on empty right after frame_start sets underflow.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pix_pop = 1'b1;
        #1;
        chk("uf_empty", pix_valid, 0);
        step();
        pix_pop = 1'b0;
        chk("uf_set",   underflow, 1);
        chk("uf_level", fifo_level, 0);
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        #1;
        chk("uf_cleared", underflow, 0);

        // Reset mid-frame with two pixels stored.
        seen = 0;
        for (int i = 0; i < 20 && fifo_level != 5'd2; i++) step();
        chk("mid_level2", fifo_level, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_rd_en", fb_rd_en, 0);
        chk("arst_addr",  fb_rd_addr, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_data",  pix_data, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_done",  frame_done, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fb_rd_en) seen++;
        end
        chk("arst_no_resume", seen, 0);

        // Full frame with the LCD popping whenever a pixel is available.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        #1;
        nrd = 0; npop = 0; errs_a = 0; errs_p = 0;
        lvl_chk = 1'b0; last_seen = 1'b0; done_chk = 1'b0;
        for (int cyc = 0; cyc < 20000 && npop < 12800; cyc++) begin
            if (last_seen && !done_chk) begin
                chk("done_after_last", frame_done, 1);
                done_chk = 1'b1;
            end
            pix_pop = pix_valid;
            #1;
            if (pix_pop) begin
                if (pix_data != npop[15:0]) errs_p++;
                npop++;
            end
            if (fb_rd_en) begin
                if (fb_rd_addr != nrd[13:0]) errs_a++;
                if (nrd == 160) chk("addr_after_159", fb_rd_addr, 160);
                if (nrd == 12799) begin
                    chk("last_addr", fb_rd_addr, 12799);
                    chk("done_before_last", frame_done, 0);
                    last_seen = 1'b1;
                end
                nrd++;
            end
            if (nrd == 5000 && !lvl_chk) begin
                chk("steady_level", fifo_level, 1);
                lvl_chk = 1'b1;
            end
            step();
        end
        pix_pop = 1'b0;
        chk("frame_pops",    npop, 12800);
        chk("frame_reads",   nrd, 12800);
        chk("pop_order_err", errs_p, 0);
        chk("addr_seq_err",  errs_a, 0);
        chk("frame_under",   underflow, 0);
        chk("frame_done",    frame_done, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (fb_rd_en) seen++;
        end
        chk("no_rd_after_done", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
